// File: rtl/demux_stream_if.sv
// demux_stream_if: bus bundle for the 1-to-NUM_CH stream demultiplexer.
//   Upstream side : i_Data, i_Sel, i_Bcast, i_Valid -> block, o_Ready <- block
//   Downstream    : o_Data, o_Valid <- block (one slot per channel),
//                   i_Ready -> block (one consumer ready per channel)
//   Status        : o_Err <- block (sticky out-of-range select seen)
// Modports:
//   slave  - the demultiplexer itself
//   master - the environment (producer plus all consumers)
interface demux_stream_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 8
);
  localparam int SEL_W = $clog2(NUM_CH);

  logic [DATA_W-1:0]        i_Data;
  logic [SEL_W-1:0]         i_Sel;
  logic                     i_Bcast;
  logic                     i_Valid;
  logic                     o_Ready;
  logic [NUM_CH*DATA_W-1:0] o_Data;
  logic [NUM_CH-1:0]        o_Valid;
  logic [NUM_CH-1:0]        i_Ready;
  logic                     o_Err;

  modport slave (
    input  i_Data, i_Sel, i_Bcast, i_Valid, i_Ready,
    output o_Ready, o_Data, o_Valid, o_Err
  );

  modport master (
    output i_Data, i_Sel, i_Bcast, i_Valid, i_Ready,
    input  o_Ready, o_Data, o_Valid, o_Err
  );
endinterface

// File: rtl/demux_stream.sv
// demux_stream: 1-to-NUM_CH stream demultiplexer with registered outputs.
//   Each accepted input word is written into the one-entry output slot of the
//   channel named by i_Sel, or into every slot when i_Bcast is set. Every
//   channel drains independently through its own valid/ready handshake.
// Parameters:
//   DATA_W  width of one data word
//   NUM_CH  number of output channels (2..64)
// Ports:
//   i_Clk   clock, all state on the rising edge
//   i_Rst   synchronous reset, active-high; clears slots, data and error flag
//   bus     demux_stream_if slave modport
//             o_Ready  combinational, depends on i_Ready of the target slot(s)
//             o_Data   channel k at bits [k*DATA_W +: DATA_W]
//             o_Valid  channel k slot holds a word
//             o_Err    sticky, set when an out-of-range unicast is accepted
module demux_stream #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 8
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  demux_stream_if.slave bus
);

  localparam int SEL_W    = $clog2(NUM_CH);
  localparam int SEL_SPAN = 1 << SEL_W;
  // With a power-of-two channel count every select value names a channel.
  localparam bit SEL_FULL = (SEL_SPAN == NUM_CH);

  logic [NUM_CH-1:0]        valid_q;
  logic [NUM_CH*DATA_W-1:0] data_q;
  logic                     err_q;

  logic [NUM_CH-1:0]        free;
  logic [SEL_SPAN-1:0]      free_pad;
  logic                     sel_ok;
  logic                     ready;
  logic                     accept;
  logic [NUM_CH-1:0]        load;
  logic                     err_set;

  // Handshake decode. free_pad extends the per-slot free vector to the full
  // select range so i_Sel can index it directly; the padding is never used
  // because out-of-range selects take the discard branch.
  always_comb begin
    free     = ~valid_q | bus.i_Ready;
    free_pad = '0;
    free_pad[NUM_CH-1:0] = free;

    sel_ok = SEL_FULL ? 1'b1 : (int'(bus.i_Sel) < NUM_CH);

    if (bus.i_Bcast) begin
      ready = &free;
    end else if (!sel_ok) begin
      ready = 1'b1;
    end else begin
      ready = free_pad[bus.i_Sel];
    end

    accept = bus.i_Valid & ready;

    load = '0;
    if (accept) begin
      if (bus.i_Bcast) begin
        load = '1;
      end else if (sel_ok) begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
          load[k] = (bus.i_Sel == SEL_W'(k));
        end
      end
    end

    err_set = accept & ~bus.i_Bcast & ~sel_ok;
  end

  // Output slots. A load only happens when the slot is free, so a stalled
  // slot (valid and not ready) keeps both data and valid unchanged. Load
  // takes priority over drain so a slot can empty and refill in one cycle.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      valid_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (load[k]) begin
          data_q[k*DATA_W +: DATA_W] <= bus.i_Data;
          valid_q[k]                 <= 1'b1;
        end else if (bus.i_Ready[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.o_Ready = ready;
    bus.o_Data  = data_q;
    bus.o_Valid = valid_q;
    bus.o_Err   = err_q;
  end

endmodule

// File: tb/tb_demux_stream.sv
module tb_demux_stream;

  localparam int DW  = 8;
  localparam int NC  = 8;
  localparam int NC6 = 6;

  logic clk = 1'b0;
  logic rst;
  logic rst6;

  always #5 clk = ~clk;

  demux_stream_if #(.DATA_W(DW), .NUM_CH(NC))  bus8 ();
  demux_stream_if #(.DATA_W(DW), .NUM_CH(NC6)) bus6 ();

  demux_stream #(.DATA_W(DW), .NUM_CH(NC)) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus8)
  );

  demux_stream #(.DATA_W(DW), .NUM_CH(NC6)) dut6 (
    .i_Clk (clk),
    .i_Rst (rst6),
    .bus   (bus6)
  );

  // Scoreboard: one queue per channel; each entry is a word and the cycle
  // from which it must be visible on the output slot.
  typedef struct {
    logic [DW-1:0] d;
    int            vis;
  } ent_t;

  ent_t          q[NC][$];
  logic [DW-1:0] last_d[NC];
  int            cyc;
  int            err_cyc;
  bit            exp_ready;
  bit            rst_prev;
  int            total;
  int            bad;

  function automatic void chk(string nm, int k, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] cyc=%0d actual=%0h expected=%0h", nm, k, cyc, act, exp);
    end
  endfunction

  // One cycle of stimulus on the 8-channel DUT plus the reference model.
  // Slots are modelled as queues: a slot is full iff its queue is non-empty.
  task automatic step(input bit r, input bit v, input logic [DW-1:0] d,
                      input logic [2:0] s, input bit b, input logic [NC-1:0] rdy);
    logic [NC-1:0] free_m;
    bit            rdy_m;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_prev) begin
      for (int k = 0; k < NC; k++) begin
        q[k].delete();
        last_d[k] = '0;
      end
      err_cyc = -1;
    end
    rst          = r;
    bus8.i_Valid = v;
    bus8.i_Data  = d;
    bus8.i_Sel   = s;
    bus8.i_Bcast = b;
    bus8.i_Ready = rdy;
    for (int k = 0; k < NC; k++) begin
      free_m[k] = (q[k].size() == 0) || rdy[k];
    end
    rdy_m     = b ? (&free_m) : free_m[s];
    exp_ready = rdy_m;
    if (!r && v && rdy_m) begin
      for (int k = 0; k < NC; k++) begin
        if (b || (int'(s) == k)) q[k].push_back('{d: d, vis: cyc + 1});
      end
    end
    rst_prev = r;
  endtask

  // Monitor: mid-cycle compare of every output against the scoreboard.
  always @(negedge clk) begin
    if (cyc >= 2) begin
      chk("o_Ready", 0, 64'(bus8.o_Ready), 64'(exp_ready));
      for (int k = 0; k < NC; k++) begin
        bit            vis;
        logic [DW-1:0] ed;
        vis = (q[k].size() != 0) && (q[k][0].vis <= cyc);
        ed  = vis ? q[k][0].d : last_d[k];
        chk("o_Valid", k, 64'(bus8.o_Valid[k]), 64'(vis));
        chk("o_Data", k, 64'(bus8.o_Data[k*DW +: DW]), 64'(ed));
        if (vis && bus8.i_Ready[k]) begin
          last_d[k] = q[k][0].d;
          void'(q[k].pop_front());
        end
      end
      chk("o_Err", 0, 64'(bus8.o_Err), 64'((err_cyc >= 0) && (err_cyc <= cyc)));
    end
  end

  initial begin
    bit            pend;
    logic [DW-1:0] rd;
    logic [2:0]    rs;
    bit            rb;
    bit            rv;

    total    = 0;
    bad      = 0;
    cyc      = 0;
    err_cyc  = -1;
    rst_prev = 1'b0;
    exp_ready = 1'b1;
    for (int k = 0; k < NC; k++) last_d[k] = '0;
    rst  = 1'b1;
    rst6 = 1'b1;
    bus6.i_Valid = 1'b0;
    bus6.i_Data  = '0;
    bus6.i_Sel   = '0;
    bus6.i_Bcast = 1'b0;
    bus6.i_Ready = '1;

    // Reset held for two cycles with a valid word on the input.
    step(1, 1, 8'h77, 3'd1, 0, 8'hFF);
    step(1, 1, 8'h77, 3'd1, 0, 8'hFF);
    step(0, 0, 8'h00, 3'd0, 0, 8'hFF);
    @(negedge clk);
    chk("rst_valid", 0, 64'(bus8.o_Valid), 64'(0));
    chk("rst_data", 0, 64'(bus8.o_Data), 64'(0));
    chk("rst_err", 0, 64'(bus8.o_Err), 64'(0));

    // Unicast sweep, back-to-back.
    for (int k = 0; k < NC; k++) step(0, 1, 8'(8'hA0 + k), 3'(k), 0, 8'hFF);
    step(0, 0, 8'h00, 3'd0, 0, 8'hFF);
    step(0, 0, 8'h00, 3'd0, 0, 8'hFF);

    // Backpressure on channel 3.
    step(0, 1, 8'h11, 3'd3, 0, 8'hF7);
    step(0, 1, 8'h22, 3'd3, 0, 8'hF7);
    step(0, 1, 8'h22, 3'd3, 0, 8'hF7);
    step(0, 1, 8'h22, 3'd3, 0, 8'hFF);
    step(0, 0, 8'h00, 3'd0, 0, 8'hFF);
    @(negedge clk);
    chk("bp_ch3", 3, 64'(bus8.o_Data[3*DW +: DW]), 64'(8'h22));

    // Broadcast blocked by a stalled channel 5, then released.
    step(0, 1, 8'h33, 3'd5, 0, 8'hDF);
    step(0, 1, 8'h5A, 3'd2, 1, 8'hDF);
    step(0, 1, 8'h5A, 3'd2, 1, 8'hDF);
    step(0, 1, 8'h5A, 3'd2, 1, 8'hFF);
    step(0, 0, 8'h00, 3'd0, 0, 8'h00);
    @(negedge clk);
    chk("bcast_valid", 0, 64'(bus8.o_Valid), 64'(8'hFF));
    chk("bcast_data", 0, 64'(bus8.o_Data), 64'h5A5A5A5A5A5A5A5A);
    step(0, 0, 8'h00, 3'd0, 0, 8'hFF);

    // Reset in the same cycle as an accept; reset wins.
    step(0, 1, 8'h44, 3'd2, 0, 8'hFB);
    step(0, 0, 8'h00, 3'd0, 0, 8'hFB);
    step(1, 1, 8'h66, 3'd4, 0, 8'hFB);
    step(0, 0, 8'h00, 3'd0, 0, 8'hFF);
    @(negedge clk);
    chk("rst_mid_valid", 0, 64'(bus8.o_Valid), 64'(0));

    // Randomised traffic; a word not accepted is held until it is.
    pend = 1'b0;
    rd = '0; rs = '0; rb = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (pend) begin
        rv = 1'b1;
      end else begin
        rv = ($urandom_range(0, 3) != 0);
        rd = 8'($urandom);
        rs = 3'($urandom);
        rb = ($urandom_range(0, 7) == 0);
      end
      step(0, rv, rd, rs, rb, 8'($urandom | $urandom));
      pend = rv && !exp_ready;
    end
    step(0, 0, 8'h00, 3'd0, 0, 8'hFF);
    step(0, 0, 8'h00, 3'd0, 0, 8'hFF);

    // Six-channel instance: out-of-range select handling.
    @(posedge clk); #1;
    rst6 = 1'b0;
    @(negedge clk);
    chk("ch6_rst_err", 0, 64'(bus6.o_Err), 64'(0));
    chk("ch6_rst_valid", 0, 64'(bus6.o_Valid), 64'(0));
    @(posedge clk); #1;
    bus6.i_Valid = 1'b1; bus6.i_Sel = 3'd7; bus6.i_Data = 8'hFF;
    @(negedge clk);
    chk("ch6_oor_ready", 0, 64'(bus6.o_Ready), 64'(1));
    @(posedge clk); #1;
    bus6.i_Valid = 1'b0;
    @(negedge clk);
    chk("ch6_oor_valid", 0, 64'(bus6.o_Valid), 64'(0));
    chk("ch6_oor_err", 0, 64'(bus6.o_Err), 64'(1));
    @(posedge clk); #1;
    bus6.i_Valid = 1'b1; bus6.i_Sel = 3'd5; bus6.i_Data = 8'h3C; bus6.i_Ready = '0;
    @(negedge clk);
    chk("ch6_in_ready", 0, 64'(bus6.o_Ready), 64'(1));
    @(posedge clk); #1;
    bus6.i_Sel = 3'd6; bus6.i_Data = 8'hC3;
    @(negedge clk);
    chk("ch6_valid5", 5, 64'(bus6.o_Valid), 64'(6'b100000));
    chk("ch6_data5", 5, 64'(bus6.o_Data[5*DW +: DW]), 64'(8'h3C));
    chk("ch6_oor6_ready", 0, 64'(bus6.o_Ready), 64'(1));
    @(posedge clk); #1;
    bus6.i_Valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("ch6_err_sticky", 0, 64'(bus6.o_Err), 64'(1));
    chk("ch6_data5_hold", 5, 64'(bus6.o_Data[5*DW +: DW]), 64'(8'h3C));
    @(posedge clk); #1;
    rst6 = 1'b1;
    @(posedge clk); #1;
    rst6 = 1'b0;
    @(negedge clk);
    chk("ch6_err_clr", 0, 64'(bus6.o_Err), 64'(0));
    chk("ch6_valid_clr", 0, 64'(bus6.o_Valid), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
